// File: rtl/imem_refill_pkg.sv
// imem_refill_pkg: shared state type and line geometry for the I-cache refill responder
package imem_refill_pkg;
  localparam int LINE_WORDS = 8;
  localparam int WORD_IDX_W = 3;
  localparam int OFFSET_W = 5;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} refill_state_t;
endpackage

// File: rtl/imem_refill_delay.sv
// imem_refill_delay: MEM_LAT-deep {valid, word index} tracker for reads still in flight
module imem_refill_delay
  import imem_refill_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [WORD_IDX_W-1:0] in_idx,
  output logic                  out_valid,
  output logic [WORD_IDX_W-1:0] out_idx,
  output logic                  empty
);
  logic [MEM_LAT-1:0] v;
  logic [MEM_LAT-1:0][WORD_IDX_W-1:0] idx;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      v <= '0;
      idx <= '0;
    end else if (clr) begin
      v <= '0;
      idx <= '0;
    end else begin
      v[0] <= in_valid;
      idx[0] <= in_idx;
      for (int k = 1; k < MEM_LAT; k++) begin
        v[k] <= v[k-1];
        idx[k] <= idx[k-1];
      end
    end
  assign out_valid = v[MEM_LAT-1];
  assign out_idx = idx[MEM_LAT-1];
  assign empty = ~|v;
endmodule

// File: rtl/imem_line_refill.sv
// imem_line_refill: critical-word-first line refill from a word-wide synchronous instruction memory
module imem_line_refill
  import imem_refill_pkg::*;
#(
  parameter int LINE_WORDS = imem_refill_pkg::LINE_WORDS,
  parameter int MEM_LAT = 1,
  parameter int MEM_AW = 14
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  input  logic                     abort,
  output logic                     mem_rd_en,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [31:0]              mem_rdata,
  output logic                     crit_valid,
  output logic [31:0]              crit_data,
  output logic                     line_valid,
  output logic [31:0]              line_addr,
  output logic [LINE_WORDS*32-1:0] line_data
);
  refill_state_t state, nxt;
  logic [WORD_IDX_W-1:0] s, i, iss_idx, out_idx;
  logic [LINE_WORDS-1:0][31:0] words;
  logic out_valid, empty, accept, clr, take, last, unused_ok;
  assign accept = state == IDLE && req_valid && !abort;
  assign clr = abort && (state == ISSUE || state == DRAIN);
  assign take = out_valid && !clr;
  assign last = take && out_idx == s + WORD_IDX_W'(LINE_WORDS - 1);
  assign iss_idx = s + i;
  assign req_ready = state == IDLE;
  assign mem_rd_en = state == ISSUE && !abort;
  assign mem_addr = mem_rd_en ? {line_addr[MEM_AW+1:OFFSET_W], iss_idx} : '0;
  // The requested word is always the first one issued, so its index equals the start index
  assign crit_valid = take && out_idx == s;
  assign crit_data = crit_valid ? mem_rdata : '0;
  assign line_valid = state == DONE;
  assign line_data = words;
  assign unused_ok = ^req_addr[1:0];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? ISSUE : IDLE;
      ISSUE:   nxt = abort ? FLUSH : (i == WORD_IDX_W'(LINE_WORDS - 1) ? DRAIN : ISSUE);
      DRAIN:   nxt = abort ? FLUSH : (last ? DONE : DRAIN);
      DONE:    nxt = IDLE;
      FLUSH:   nxt = empty ? IDLE : FLUSH;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      line_addr <= '0;
      s <= '0;
      i <= '0;
      words <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        line_addr <= {req_addr[31:OFFSET_W], OFFSET_W'(0)};
        s <= req_addr[OFFSET_W-1:2];
        i <= '0;
      end
      if (mem_rd_en) i <= i + 1'b1;
      if (take) words[out_idx] <= mem_rdata;
    end
  imem_refill_delay #(.MEM_LAT(MEM_LAT)) u_delay (
    .CLK(CLK),
    .RESET(RESET),
    .clr(clr),
    .in_valid(mem_rd_en),
    .in_idx(iss_idx),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .empty(empty)
  );
endmodule

// File: doc/imem_line_refill.md
Name: imem_line_refill

Overview:
Responder side of the I-cache miss/refill interface. It accepts a block-fill request from the cache FSM and reads the 8 words of the line from a word-wide synchronous instruction memory, one per cycle. Words are fetched critical-word-first in wrap order, and the requested word is forwarded early. The block sits between the Cache/CacheFSM pair and the backing instruction RAM, replacing the combinational 8-word imem read.

Parameters:
LINE_WORDS, 8, words per cache line; fixed by the 32-byte line; must be a power of 2.
MEM_LAT, 1, cycles from mem_rd_en to mem_rdata valid; legal range 1..4.
MEM_AW, 14, word-address width of the backing memory.

Ports:
CLK  in  1  clock
RESET  in  1  reset
req_valid  in  1  cache requests a line fill
req_addr  in  32  byte address of the missing instruction
req_ready  out  1  responder idle and able to accept a request
abort  in  1  cancel the fill in flight (wrong-path miss)
mem_rd_en  out  1  backing memory read strobe
mem_addr  out  MEM_AW  backing memory word address
mem_rdata  in  32  backing memory read data, valid MEM_LAT cycles after mem_rd_en
crit_valid  out  1  one-cycle pulse: requested word available
crit_data  out  32  requested word
line_valid  out  1  one-cycle pulse: full line assembled (drives cache update)
line_addr  out  32  block-aligned address {req_addr[31:5],5'b0}
line_data  out  256  assembled line; w0 at [31:0], w7 at [255:224]

Behaviour:
- Interface: reset RESET, asynchronous, active-high; clock CLK.
- Reset values: state=IDLE, req_ready=1, mem_rd_en=0, crit_valid=0, line_valid=0. mem_addr, crit_data, line_addr and line_data reset to 0. The delay line is cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE, FLUSH.
- IDLE:
  - req_ready=1.
  - req_valid & !abort at an edge: latch line_addr, set start index s=req_addr[4:2], issue count i=0, go ISSUE.
  - req_valid & abort together: request not accepted, stay IDLE.
- ISSUE:
  - req_ready=0, mem_rd_en=1, mem_addr={line_addr[MEM_AW+1:5], (s+i) mod 8}.
  - i increments every cycle. After the issue with i=7, go DRAIN.
  - The 3-bit word index wraps modulo 8. Example: s=6 yields order 6,7,0,1,...,5.
- Return tracking:
  - A MEM_LAT-deep delay line carries {valid, word index} for each issue.
  - When a valid entry emerges, mem_rdata is written into line_data slot [index].
  - The first return (i=0) also drives crit_data=mem_rdata and crit_valid=1 for exactly that cycle.
- DRAIN: mem_rd_en=0. When the last outstanding return has been captured, go DONE.
- DONE: line_valid=1 for one cycle while line_data is stable, then go IDLE.
- Latency, with acceptance at edge 0:
  - issues occur in cycles 1..8;
  - crit_valid is asserted in cycle 1+MEM_LAT;
  - line_valid is asserted in cycle 9+MEM_LAT.
- line_data and line_addr hold their values after DONE until the next accepted request.
- Abort:
  - abort in ISSUE or DRAIN: stop issuing immediately (mem_rd_en=0 that cycle), go FLUSH.
  - FLUSH: returns still in flight are discarded. crit_valid and line_valid are suppressed, even if the critical word returns in the same cycle as abort.
  - FLUSH → IDLE once the delay line is empty, i.e. at most MEM_LAT cycles.
  - abort in DONE is ignored; the line completes.
- RESET mid-fill: everything returns to reset values immediately. No pulse is emitted and returns in flight are lost.
- mem_rdata is ignored whenever no valid delay-line entry emerges.

Decomposition:
- Package imem_refill_pkg holds:
  - refill_state_t enum (IDLE, ISSUE, DRAIN, DONE, FLUSH);
  - localparams LINE_WORDS=8, WORD_IDX_W=3, OFFSET_W=5.
- One sub-module, imem_refill_delay: a parameterised MEM_LAT-stage shift register of {valid, idx[2:0]}, with synchronous clear on abort and asynchronous clear on RESET. It outputs an empty flag.

Test Plan:
- Memory model where word at address n equals 32'hA000_0000+n, MEM_LAT=1; req_addr=32'h0000_0040 → mem_addr sequence 16..23. crit_data=32'hA000_0010 in cycle 2. line_valid in cycle 10 with line_data word k = 32'hA000_0010+k.
- Wrap order: req_addr=32'h0000_005C (s=7) → issue order 23,16,17,...,22. crit_data=32'hA000_0017. Final line identical to the previous case.
- MEM_LAT=3 → crit_valid in cycle 4, line_valid in cycle 12. Exactly 8 mem_rd_en cycles and no early line_valid.
- abort in cycle 4 of a fill → mem_rd_en drops that cycle and line_valid never pulses. req_ready returns within MEM_LAT+1 cycles. A new request to 32'h0000_0080 then completes with the correct data, with no stale words.
- req_valid held during a fill → req_ready=0 and the request is not accepted until the cycle after line_valid. Simultaneous req_valid&abort in IDLE → not accepted.
- RESET asserted in cycle 5 (DRAIN/ISSUE) → all outputs at reset values immediately. No crit_valid or line_valid appears afterwards.
